// File: rtl/keychain_pkg.sv
// Shared types and default widths for the modular-exponentiation scheduler.
package keychain_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StRespond
    } sched_state_t;

    localparam int unsigned DEF_MSG_BYTES = 2;
    localparam int unsigned DEF_KEY_BYTES = 4;
    localparam int unsigned MSG_W = 8 * DEF_MSG_BYTES;
    localparam int unsigned KEY_W = 8 * DEF_KEY_BYTES;

endpackage

// File: rtl/expmod_scheduler_rr_pick.sv
// Combinational round-robin search: first asserted request after last_grant, with wrap.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last_grant) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/expmod_scheduler.sv
// Shares one exponent/modulus engine among NUM_REQ requesters with round-robin
// arbitration, a valid/ready response path and a watchdog on the engine.
module expmod_scheduler
    import keychain_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned KEY_BYTES      = KEY_W / 8,
    parameter int unsigned MSG_BYTES      = MSG_W / 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    input  logic [NUM_REQ*8*MSG_BYTES-1:0] req_message_in,
    input  logic [NUM_REQ*8*KEY_BYTES-1:0] req_exponent_in,
    input  logic [NUM_REQ*8*KEY_BYTES-1:0] req_modulus_in,
    output logic [NUM_REQ-1:0]             req_ack_out,
    output logic [NUM_REQ-1:0]             resp_valid_out,
    input  logic [NUM_REQ-1:0]             resp_ready_in,
    output logic [8*KEY_BYTES-1:0]         resp_data_out,
    output logic                           resp_error_out,
    output logic                           eng_start_out,
    input  logic                           eng_busy_in,
    input  logic                           eng_valid_in,
    output logic [8*MSG_BYTES-1:0]         eng_message_out,
    output logic [8*KEY_BYTES-1:0]         eng_exponent_out,
    output logic [8*KEY_BYTES-1:0]         eng_modulus_out,
    input  logic [8*KEY_BYTES-1:0]         eng_result_in,
    output logic                           busy_out,
    output logic [$clog2(NUM_REQ)-1:0]     grant_out
);

    localparam int unsigned IW  = $clog2(NUM_REQ);
    localparam int unsigned KW  = 8 * KEY_BYTES;
    localparam int unsigned MW  = 8 * MSG_BYTES;
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES);

    sched_state_t     state_q, state_d;
    logic [IW-1:0]    last_q, last_d, grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d, rvalid_q, rvalid_d;
    logic             err_q, err_d, start_q, start_d, busy_q, busy_d;
    logic [KW-1:0]    data_q, data_d, exp_q, exp_d, mod_q, mod_d;
    logic [MW-1:0]    msg_q, msg_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_rr_pick (
        .req        (req_valid_in),
        .last_grant (last_q),
        .found      (pick_found),
        .index      (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        ack_d    = '0;
        rvalid_d = rvalid_q;
        err_d    = err_q;
        start_d  = 1'b0;
        data_d   = data_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        msg_d    = msg_q;
        wd_d     = wd_q;
        unique case (state_q)
            StIdle: begin
                // An engine still busy after an abort must drain before reuse.
                if (pick_found && !eng_busy_in) begin
                    grant_d         = pick_idx;
                    ack_d[pick_idx] = 1'b1;
                    msg_d           = req_message_in[32'(pick_idx) * MW +: MW];
                    exp_d           = req_exponent_in[32'(pick_idx) * KW +: KW];
                    mod_d           = req_modulus_in[32'(pick_idx) * KW +: KW];
                    state_d         = StIssue;
                end
            end
            StIssue: begin
                start_d = 1'b1;
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                if (eng_valid_in) begin
                    data_d            = eng_result_in;
                    err_d             = 1'b0;
                    rvalid_d          = '0;
                    rvalid_d[grant_q] = 1'b1;
                    state_d           = StRespond;
                end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                    data_d            = '0;
                    err_d             = 1'b1;
                    rvalid_d          = '0;
                    rvalid_d[grant_q] = 1'b1;
                    state_d           = StRespond;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StRespond: begin
                if (resp_ready_in[grant_q]) begin
                    rvalid_d = '0;
                    err_d    = 1'b0;
                    last_d   = grant_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= StIdle;
            last_q   <= IW'(NUM_REQ - 1);
            grant_q  <= '0;
            ack_q    <= '0;
            rvalid_q <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            msg_q    <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            data_q   <= data_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            msg_q    <= msg_d;
            wd_q     <= wd_d;
        end
    end

    assign req_ack_out      = ack_q;
    assign resp_valid_out   = rvalid_q;
    assign resp_data_out    = data_q;
    assign resp_error_out   = err_q;
    assign eng_start_out    = start_q;
    assign eng_message_out  = msg_q;
    assign eng_exponent_out = exp_q;
    assign eng_modulus_out  = mod_q;
    assign busy_out         = busy_q;
    assign grant_out        = grant_q;

endmodule

// File: tb/tb_expmod_scheduler.sv
// Self-checking bench: behavioural engine plus arithmetic/round-robin reference model.
module tb_expmod_scheduler;

    localparam int unsigned NR = 3;
    localparam int unsigned KB = 4;
    localparam int unsigned MB = 2;
    localparam int unsigned TO = 16;
    localparam int unsigned KW = 8 * KB;
    localparam int unsigned MW = 8 * MB;
    localparam int unsigned IW = $clog2(NR);

    logic             clk_in, rst_in;
    logic [NR-1:0]    req_valid_in, req_ack_out, resp_valid_out, resp_ready_in;
    logic [NR*MW-1:0] req_message_in;
    logic [NR*KW-1:0] req_exponent_in, req_modulus_in;
    logic [KW-1:0]    resp_data_out, eng_exponent_out, eng_modulus_out, eng_result_in;
    logic [MW-1:0]    eng_message_out;
    logic             resp_error_out, eng_start_out, eng_busy_in, eng_valid_in, busy_out;
    logic [IW-1:0]    grant_out;

    expmod_scheduler #(
        .NUM_REQ        (NR),
        .KEY_BYTES      (KB),
        .MSG_BYTES      (MB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .req_valid_in     (req_valid_in),
        .req_message_in   (req_message_in),
        .req_exponent_in  (req_exponent_in),
        .req_modulus_in   (req_modulus_in),
        .req_ack_out      (req_ack_out),
        .resp_valid_out   (resp_valid_out),
        .resp_ready_in    (resp_ready_in),
        .resp_data_out    (resp_data_out),
        .resp_error_out   (resp_error_out),
        .eng_start_out    (eng_start_out),
        .eng_busy_in      (eng_busy_in),
        .eng_valid_in     (eng_valid_in),
        .eng_message_out  (eng_message_out),
        .eng_exponent_out (eng_exponent_out),
        .eng_modulus_out  (eng_modulus_out),
        .eng_result_in    (eng_result_in),
        .busy_out         (busy_out),
        .grant_out        (grant_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [MW-1:0] op_m [NR];
    logic [KW-1:0] op_e [NR];
    logic [KW-1:0] op_n [NR];
    int            model_last;

    function automatic logic [KW-1:0] modexp(input logic [MW-1:0] m, input logic [KW-1:0] e,
                                             input logic [KW-1:0] n);
        longint unsigned r, b, nn;
        nn = 64'(n);
        r  = 64'd1 % nn;
        b  = 64'(m) % nn;
        for (int i = 0; i < int'(KW); i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[KW-1:0];
    endfunction

    function automatic int model_pick(input logic [NR-1:0] mask);
        for (int k = 1; k <= int'(NR); k++) begin
            if (mask[(model_last + k) % int'(NR)]) return (model_last + k) % int'(NR);
        end
        return 0;
    endfunction

    function automatic logic [NR-1:0] onehot(input int g);
        logic [NR-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    // Behavioural engine: busy from start until its single-cycle valid, eng_lat cycles later.
    logic          model_busy, model_valid, eng_manual, man_busy, man_valid;
    logic [KW-1:0] model_result;
    int            model_cnt, eng_lat;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            model_busy   <= 1'b0;
            model_valid  <= 1'b0;
            model_cnt    <= 0;
            model_result <= '0;
        end else begin
            model_valid <= 1'b0;
            if (model_busy) begin
                if (model_cnt >= eng_lat) begin
                    model_valid <= 1'b1;
                    model_busy  <= 1'b0;
                end else begin
                    model_cnt <= model_cnt + 1;
                end
            end else if (eng_start_out && !eng_manual) begin
                model_busy   <= 1'b1;
                model_cnt    <= 1;
                model_result <= modexp(eng_message_out, eng_exponent_out, eng_modulus_out);
            end
        end
    end

    assign eng_busy_in   = eng_manual ? man_busy : model_busy;
    assign eng_valid_in  = eng_manual ? man_valid : model_valid;
    assign eng_result_in = model_result;

    task automatic set_req(input int i, input logic [MW-1:0] m, input logic [KW-1:0] e,
                           input logic [KW-1:0] n);
        op_m[i] = m;
        op_e[i] = e;
        op_n[i] = n;
        req_message_in[i*MW +: MW]  = m;
        req_exponent_in[i*KW +: KW] = e;
        req_modulus_in[i*KW +: KW]  = n;
        req_valid_in[i] = 1'b1;
    endtask

    task automatic set_rand_req(input int i);
        set_req(i, MW'($urandom), KW'($urandom), KW'($urandom) | 1);
    endtask

    task automatic wait_ack(output logic [NR-1:0] vec, output bit ok);
        ok  = 1'b0;
        vec = '0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk_in);
            if (req_ack_out != '0) begin
                ok  = 1'b1;
                vec = req_ack_out;
            end
        end
        req_valid_in = req_valid_in & ~vec;
    endtask

    task automatic wait_resp(output logic [NR-1:0] vec, output logic [KW-1:0] data,
                             output logic err, output bit ok);
        ok = 1'b0;
        vec = '0;
        data = '0;
        err = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk_in);
            if (resp_valid_out != '0) begin
                ok   = 1'b1;
                vec  = resp_valid_out;
                data = resp_data_out;
                err  = resp_error_out;
            end
        end
    endtask

    task automatic pulse_ready(input int g);
        resp_ready_in[g] = 1'b1;
        @(negedge clk_in);
        resp_ready_in[g] = 1'b0;
    endtask

    // Serve one job for whichever requester the model expects to win.
    task automatic serve_one(input string tag);
        logic [NR-1:0] av, rv;
        logic [KW-1:0] d;
        logic          er;
        bit            ok;
        int            g;
        g = model_pick(req_valid_in);
        wait_ack(av, ok);
        n_checks++;
        if (av !== onehot(g) || !ok) begin
            n_fail++;
            $display("FAIL %s ack: got %b expected %b", tag, av, onehot(g));
        end
        n_checks++;
        if (grant_out !== IW'(g)) begin
            n_fail++;
            $display("FAIL %s grant: got %0d expected %0d", tag, grant_out, g);
        end
        wait_resp(rv, d, er, ok);
        n_checks++;
        if (!ok || rv !== onehot(g) || d !== modexp(op_m[g], op_e[g], op_n[g]) || er !== 1'b0) begin
            n_fail++;
            $display("FAIL %s resp: got v=%b d=%h e=%b expected v=%b d=%h e=0", tag, rv, d, er,
                     onehot(g), modexp(op_m[g], op_e[g], op_n[g]));
        end
        repeat ($urandom_range(0, 3)) @(negedge clk_in);
        pulse_ready(g);
        model_last = g;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        req_valid_in = '0;
        resp_ready_in = '0;
        req_message_in = '0;
        req_exponent_in = '0;
        req_modulus_in = '0;
        eng_manual = 1'b0;
        man_busy = 1'b0;
        man_valid = 1'b0;
        eng_lat = 10;
        #2 rst_in = 1'b1;
        #2;
        n_checks++;
        if ({req_ack_out, resp_valid_out, resp_error_out, eng_start_out, busy_out, grant_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ack=%b rv=%b err=%b st=%b busy=%b g=%0d expected all 0",
                     req_ack_out, resp_valid_out, resp_error_out, eng_start_out, busy_out, grant_out);
        end
        n_checks++;
        if ({resp_data_out, eng_message_out, eng_exponent_out, eng_modulus_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got d=%h m=%h e=%h n=%h expected 0", resp_data_out,
                     eng_message_out, eng_exponent_out, eng_modulus_out);
        end
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        model_last = NR - 1;
    endtask

    task automatic test_alternate();
        for (int r = 0; r < 2; r++) begin
            set_rand_req(0);
            set_rand_req(1);
            serve_one("alt_first");
            serve_one("alt_second");
        end
    endtask

    task automatic test_single();
        bit seen;
        set_req(0, 16'd4, 32'd13, 32'd497);
        @(negedge clk_in);
        n_checks++;
        if (req_ack_out !== 3'b001 || eng_start_out !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: got ack=%b start=%b expected 001/0", req_ack_out, eng_start_out);
        end
        req_valid_in[0] = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if (req_ack_out !== 3'b000 || eng_start_out !== 1'b1 || busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL single_start: got ack=%b start=%b busy=%b expected 000/1/1",
                     req_ack_out, eng_start_out, busy_out);
        end
        n_checks++;
        if (eng_message_out !== 16'd4 || eng_exponent_out !== 32'd13 || eng_modulus_out !== 32'd497) begin
            n_fail++;
            $display("FAIL single_operands: got %0d/%0d/%0d expected 4/13/497", eng_message_out,
                     eng_exponent_out, eng_modulus_out);
        end
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk_in);
            if (eng_valid_in) seen = 1'b1;
        end
        @(negedge clk_in);
        n_checks++;
        if (!seen || resp_valid_out !== 3'b001 || resp_data_out !== 32'd445 || resp_error_out !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resp: got v=%b d=%0d e=%b expected 001/445/0", resp_valid_out,
                     resp_data_out, resp_error_out);
        end
        pulse_ready(0);
        n_checks++;
        if (resp_valid_out !== '0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: got v=%b busy=%b expected 0/0", resp_valid_out, busy_out);
        end
        model_last = 0;
    endtask

    task automatic test_timeout();
        int c;
        bit seen;
        eng_manual = 1'b1;
        set_rand_req(1);
        @(negedge clk_in);
        n_checks++;
        if (req_ack_out !== 3'b010) begin
            n_fail++;
            $display("FAIL to_ack: got %b expected 010", req_ack_out);
        end
        req_valid_in[1] = 1'b0;
        @(negedge clk_in);
        man_busy = 1'b1;
        n_checks++;
        if (eng_start_out !== 1'b1) begin
            n_fail++;
            $display("FAIL to_start: got %b expected 1", eng_start_out);
        end
        c = 0;
        seen = 1'b0;
        while (!seen && c < 40) begin
            @(negedge clk_in);
            c++;
            if (resp_valid_out != '0) seen = 1'b1;
        end
        n_checks++;
        if (c != int'(TO) || resp_valid_out !== 3'b010 || resp_error_out !== 1'b1 || resp_data_out !== '0) begin
            n_fail++;
            $display("FAIL to_resp: got cyc=%0d v=%b e=%b d=%h expected %0d/010/1/0", c,
                     resp_valid_out, resp_error_out, resp_data_out, TO);
        end
        pulse_ready(1);
        model_last = 1;
        set_rand_req(0);
        for (int k = 0; k < 20; k++) begin
            man_valid = (k == 5);
            @(negedge clk_in);
            n_checks++;
            if (req_ack_out !== '0 || resp_valid_out !== '0 || busy_out !== 1'b0) begin
                n_fail++;
                $display("FAIL to_busy_hold[%0d]: got ack=%b v=%b busy=%b expected 0/0/0", k,
                         req_ack_out, resp_valid_out, busy_out);
            end
        end
        man_valid = 1'b0;
        man_busy = 1'b0;
        eng_manual = 1'b0;
        serve_one("to_after_busy");
    endtask

    task automatic test_respond_hold();
        logic [NR-1:0] av, rv;
        logic [KW-1:0] d;
        logic          er;
        bit            ok;
        set_rand_req(1);
        wait_ack(av, ok);
        n_checks++;
        if (!ok || av !== 3'b010) begin
            n_fail++;
            $display("FAIL hold_ack: got %b expected 010", av);
        end
        wait_resp(rv, d, er, ok);
        n_checks++;
        if (!ok || d !== modexp(op_m[1], op_e[1], op_n[1])) begin
            n_fail++;
            $display("FAIL hold_data: got %h expected %h", d, modexp(op_m[1], op_e[1], op_n[1]));
        end
        set_rand_req(0);
        for (int c = 0; c < 10; c++) begin
            resp_ready_in[0] = (c % 2 == 1);
            @(negedge clk_in);
            n_checks++;
            if (resp_valid_out !== 3'b010 || resp_data_out !== d || req_ack_out !== '0) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: got v=%b d=%h ack=%b expected 010/%h/000", c,
                         resp_valid_out, resp_data_out, req_ack_out, d);
            end
        end
        resp_ready_in[0] = 1'b0;
        pulse_ready(1);
        model_last = 1;
        serve_one("hold_next");
    endtask

    task automatic test_random();
        for (int j = 0; j < 20; j++) begin
            for (int i = 0; i < int'(NR); i++) begin
                if (!req_valid_in[i] && $urandom_range(0, 1) == 1) set_rand_req(i);
            end
            if (req_valid_in == '0) set_rand_req(int'($urandom_range(0, NR - 1)));
            eng_lat = int'($urandom_range(1, 12));
            serve_one("random");
        end
        while (req_valid_in != '0) serve_one("random_drain");
    endtask

    task automatic test_async_reset();
        logic [NR-1:0] av;
        bit            ok;
        eng_lat = 10;
        set_rand_req(2);
        wait_ack(av, ok);
        repeat (4) @(negedge clk_in);
        n_checks++;
        if (busy_out !== 1'b1 || resp_valid_out !== '0) begin
            n_fail++;
            $display("FAIL arst_pre: got busy=%b v=%b expected 1/0", busy_out, resp_valid_out);
        end
        #2 rst_in = 1'b1;
        #1;
        n_checks++;
        if ({req_ack_out, resp_valid_out, resp_error_out, eng_start_out, busy_out, grant_out} !== '0) begin
            n_fail++;
            $display("FAIL arst_ctrl: got ack=%b v=%b e=%b st=%b busy=%b g=%0d expected all 0",
                     req_ack_out, resp_valid_out, resp_error_out, eng_start_out, busy_out, grant_out);
        end
        n_checks++;
        if ({resp_data_out, eng_message_out, eng_exponent_out, eng_modulus_out} !== '0) begin
            n_fail++;
            $display("FAIL arst_data: got d=%h m=%h e=%h n=%h expected 0", resp_data_out,
                     eng_message_out, eng_exponent_out, eng_modulus_out);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        model_last = NR - 1;
        set_rand_req(0);
        set_rand_req(1);
        serve_one("arst_first");
        serve_one("arst_second");
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single();
        test_timeout();
        test_respond_hold();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
